// File: rtl/vita49_sched_pkg.sv
// rtl/vita49_sched_pkg.sv - shared types and helpers for the VITA-49 timed-command scheduler
package vita49_sched_pkg;

  localparam int TS_W      = 96;
  localparam int ACT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARMED,
    FIRE
  } state_t;

  typedef struct packed {
    logic [31:0]          tsi;
    logic [63:0]          tsf;
    logic [ACT_W_DEF-1:0] action;
  } cmd_t;

  // {tsi,tsf} compared as one unsigned word so a fractional rollover orders correctly.
  function automatic logic ts_reached(input logic [TS_W-1:0] now_ts,
                                      input logic [TS_W-1:0] tgt_ts);
    return now_ts >= tgt_ts;
  endfunction

endpackage

// File: rtl/vita49_sched_if.sv
// rtl/vita49_sched_if.sv - timed-command offer channel (host side to scheduler)
interface vita49_sched_if #(
  parameter int ACT_W = 4
);

  logic [31:0]      cmd_tsi;
  logic [63:0]      cmd_tsf;
  logic [ACT_W-1:0] cmd_action;
  logic             cmd_valid;
  logic             cmd_ready;

  modport master (
    output cmd_tsi,
    output cmd_tsf,
    output cmd_action,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_tsi,
    input  cmd_tsf,
    input  cmd_action,
    input  cmd_valid,
    output cmd_ready
  );

endinterface

// File: rtl/vita49_sched_fifo.sv
// rtl/vita49_sched_fifo.sv - synchronous command FIFO with combinational head read
module vita49_sched_fifo
  import vita49_sched_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = cmd_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra MSB so full and empty differ only in that bit.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign head    = mem[rptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vita49_sched.sv
// rtl/vita49_sched.sv - timed-command scheduler: fires queued actions when {tsi,tsf} reaches target
module vita49_sched
  import vita49_sched_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ACT_W  = 4,
  parameter int LCNT_W = 16
) (
  input  logic                   samp_clk,
  input  logic                   ARESETN,
  input  logic [31:0]            tsi,
  input  logic [63:0]            tsf,
  vita49_sched_if.slave          cmd,
  input  logic                   flush,
  output logic                   fire,
  output logic [ACT_W-1:0]       fire_action,
  output logic                   late,
  output logic [LCNT_W-1:0]      late_cnt,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Same layout as cmd_t, with the action field sized by this instance's ACT_W.
  typedef struct packed {
    logic [31:0]      tsi;
    logic [63:0]      tsf;
    logic [ACT_W-1:0] action;
  } entry_t;

  entry_t            push_data;
  entry_t            head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  state_t            state;
  logic [TS_W-1:0]   tgt_ts;
  logic [ACT_W-1:0]  tgt_act;
  logic              first_armed;
  logic [TS_W-1:0]   now_ts;
  logic              due;
  logic              past;

  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  assign pop           = (state == FIRE);
  assign push_data     = '{tsi: cmd.cmd_tsi, tsf: cmd.cmd_tsf, action: cmd.cmd_action};
  assign busy          = (state != IDLE) || !empty;
  assign now_ts        = {tsi, tsf};
  assign due           = ts_reached(now_ts, tgt_ts);
  assign past          = now_ts > tgt_ts;

  vita49_sched_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (samp_clk),
    .rst_n     (ARESETN),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge samp_clk or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      tgt_ts      <= '0;
      tgt_act     <= '0;
      first_armed <= 1'b0;
      fire        <= 1'b0;
      fire_action <= '0;
      late        <= 1'b0;
      late_cnt    <= '0;
    end else begin
      fire        <= 1'b0;
      fire_action <= '0;
      late        <= 1'b0;
      // late_cnt survives flush; only reset clears it.
      if (state == FIRE && late && late_cnt != '1) late_cnt <= late_cnt + 1'b1;
      if (flush) begin
        state       <= IDLE;
        first_armed <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!empty) state <= LOAD;
          end
          LOAD: begin
            tgt_ts      <= {head.tsi, head.tsf};
            tgt_act     <= head.action;
            first_armed <= 1'b1;
            state       <= ARMED;
          end
          ARMED: begin
            first_armed <= 1'b0;
            if (due) begin
              state       <= FIRE;
              fire        <= 1'b1;
              fire_action <= tgt_act;
              // Only a target already behind time on arming counts as late.
              late        <= past && first_armed;
            end
          end
          FIRE: begin
            state <= (count > CW'(1)) ? LOAD : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vita49_sched.sv
// tb/tb_vita49_sched.sv - self-checking bench for vita49_sched with a queue-level reference model
module tb_vita49_sched;
  import vita49_sched_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ACT_W  = 4;
  localparam int LCNT_W = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              samp_clk = 1'b0;
  logic              ARESETN  = 1'b0;
  logic [31:0]       tsi;
  logic [63:0]       tsf;
  logic              flush;
  logic              fire;
  logic [ACT_W-1:0]  fire_action;
  logic              late;
  logic [LCNT_W-1:0] late_cnt;
  logic [CW-1:0]     count;
  logic              busy;

  vita49_sched_if #(.ACT_W(ACT_W)) cmd_if ();

  vita49_sched #(
    .DEPTH  (DEPTH),
    .ACT_W  (ACT_W),
    .LCNT_W (LCNT_W)
  ) dut (
    .samp_clk    (samp_clk),
    .ARESETN     (ARESETN),
    .tsi         (tsi),
    .tsf         (tsf),
    .cmd         (cmd_if.slave),
    .flush       (flush),
    .fire        (fire),
    .fire_action (fire_action),
    .late        (late),
    .late_cnt    (late_cnt),
    .count       (count),
    .busy        (busy)
  );

  always #5 samp_clk = ~samp_clk;

  typedef struct {
    logic [95:0]      tgt;
    logic [ACT_W-1:0] act;
    int               c;
  } ent_t;

  ent_t             q[$];
  int               cyc     = 0;
  int               fprev   = -100;
  int               mcnt    = 0;
  int               lcnt    = 0;
  bit               fire_now = 1'b0;
  bit               late_now = 1'b0;
  logic [ACT_W-1:0] act_now  = '0;
  int               checks   = 0;
  int               failures = 0;

  int               dfc[$];
  logic [ACT_W-1:0] dfa[$];
  bit               dfl[$];

  logic [95:0]      ts_v   = '0;
  logic [95:0]      ctgt   = '0;
  logic [ACT_W-1:0] cact   = '0;
  bit               cvalid = 1'b0;
  bit               cflush = 1'b0;

  task automatic expect_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One sample-clock cycle: drive, sample against the model, then advance the model.
  task automatic step();
    bit rdy;
    int a;
    @(posedge samp_clk);
    #1;
    {tsi, tsf}        = ts_v;
    cmd_if.cmd_tsi    = ctgt[95:64];
    cmd_if.cmd_tsf    = ctgt[63:0];
    cmd_if.cmd_action = cact;
    cmd_if.cmd_valid  = cvalid;
    flush             = cflush;
    @(negedge samp_clk);
    rdy = (mcnt != DEPTH);
    expect_eq("cmd_ready", cmd_if.cmd_ready, rdy);
    expect_eq("count", count, mcnt);
    expect_eq("busy", busy, mcnt != 0);
    expect_eq("fire", fire, fire_now);
    expect_eq("fire_action", fire_action, fire_now ? act_now : '0);
    expect_eq("late", late, fire_now && late_now);
    expect_eq("late_cnt", late_cnt, lcnt);
    if (fire) begin
      dfc.push_back(cyc);
      dfa.push_back(fire_action);
      dfl.push_back(late);
    end
    if (fire_now) begin
      if (late_now && lcnt != (1 << LCNT_W) - 1) lcnt++;
    end
    if (cflush) begin
      q.delete();
      mcnt     = 0;
      fire_now = 1'b0;
      fprev    = cyc - 1;
    end else begin
      if (fire_now) begin
        void'(q.pop_front());
        fprev = cyc;
        mcnt--;
      end
      if (cvalid && rdy) begin
        q.push_back('{tgt: ctgt, act: cact, c: cyc});
        mcnt++;
      end
      fire_now = 1'b0;
      if (q.size() > 0) begin
        a = (((q[0].c + 2) > (fprev + 1)) ? (q[0].c + 2) : (fprev + 1)) + 1;
        if (cyc >= a && ts_v >= q[0].tgt) begin
          fire_now = 1'b1;
          act_now  = q[0].act;
          late_now = (cyc == a) && (ts_v > q[0].tgt);
        end
      end
    end
    cyc++;
  endtask

  task automatic fire_at(input string tag, input int idx, input int exp_cyc,
                         input int exp_act, input bit exp_late);
    int c;
    int act;
    bit l;
    c   = -1;
    act = -1;
    l   = 1'b0;
    if (dfc.size() > idx) begin
      c   = dfc[idx];
      act = int'(dfa[idx]);
      l   = dfl[idx];
    end
    expect_eq({tag, "_cyc"}, c, exp_cyc);
    expect_eq({tag, "_act"}, act, exp_act);
    expect_eq({tag, "_late"}, l, exp_late);
  endtask

  task automatic push_cmd(input logic [31:0] ti, input logic [63:0] tf, input logic [ACT_W-1:0] act);
    ctgt   = {ti, tf};
    cact   = act;
    cvalid = 1'b1;
    step();
    cvalid = 1'b0;
  endtask

  initial begin
    int n0;
    int t0;
    int t1;
    int r;
    logic [95:0] tt;

    tsi = 32'd10;
    tsf = '0;
    flush = 1'b0;
    cmd_if.cmd_tsi = '0;
    cmd_if.cmd_tsf = '0;
    cmd_if.cmd_action = '0;
    cmd_if.cmd_valid = 1'b0;
    repeat (3) @(negedge samp_clk);
    expect_eq("rst_ready", cmd_if.cmd_ready, 1);
    expect_eq("rst_count", count, 0);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_fire", fire, 0);
    expect_eq("rst_late", late, 0);
    expect_eq("rst_late_cnt", late_cnt, 0);
    @(posedge samp_clk);
    #1 ARESETN = 1'b1;

    ts_v = {32'd10, 64'd0};
    repeat (100) step();
    expect_eq("idle_no_fire", dfc.size(), 0);

    // Future command: fires the cycle after tsf=50 is presented.
    n0 = dfc.size();
    t0 = cyc;
    push_cmd(32'd10, 64'd50, 4'd3);
    for (int i = 0; i < 60; i++) begin
      ts_v = ts_v + 96'd1;
      step();
    end
    expect_eq("future_nfire", dfc.size() - n0, 1);
    fire_at("future", n0, t0 + 51, 3, 1'b0);

    // Already-past target: late fire in cycle 4 after the accept.
    n0 = dfc.size();
    ts_v = {32'd20, 64'd0};
    t0 = cyc;
    push_cmd(32'd19, 64'd0, 4'd5);
    repeat (8) step();
    fire_at("late", n0, t0 + 4, 5, 1'b1);
    expect_eq("late_cnt_one", late_cnt, 1);

    // Fractional at max must not reach the next integer second.
    n0 = dfc.size();
    ts_v = {32'd7, 64'hFFFF_FFFF_FFFF_FFFF};
    push_cmd(32'd8, 64'd0, 4'd9);
    repeat (6) step();
    expect_eq("carry_nofire", dfc.size() - n0, 0);
    ts_v = {32'd8, 64'd0};
    t1 = cyc;
    repeat (4) step();
    fire_at("carry", n0, t1 + 1, 9, 1'b0);

    // Fill the queue, refuse a fifth push, then drain in order.
    n0 = dfc.size();
    ts_v = {32'd29, 64'd0};
    for (int k = 1; k <= 4; k++) push_cmd(32'd30, 64'd0, ACT_W'(k));
    push_cmd(32'd30, 64'd0, 4'd6);
    expect_eq("full_ready", cmd_if.cmd_ready, 0);
    expect_eq("full_count", count, 4);
    ts_v = {32'd30, 64'd0};
    repeat (20) step();
    expect_eq("order_nfire", dfc.size() - n0, 4);
    for (int k = 0; k < 4; k++) begin
      r = (dfc.size() > n0 + k) ? int'(dfa[n0 + k]) : -1;
      expect_eq("order_act", r, k + 1);
      if (k > 0 && dfc.size() > n0 + k)
        expect_eq("order_gap", (dfc[n0 + k] - dfc[n0 + k - 1]) >= 3, 1);
    end

    // Flush while armed, with a push on the same edge.
    n0 = dfc.size();
    ts_v = {32'd40, 64'd0};
    for (int k = 0; k < 3; k++) push_cmd(32'd50, 64'd0, 4'd7);
    repeat (4) step();
    cflush = 1'b1;
    cvalid = 1'b1;
    ctgt   = {32'd40, 64'd0};
    step();
    cflush = 1'b0;
    cvalid = 1'b0;
    step();
    expect_eq("flush_count", count, 0);
    expect_eq("flush_busy", busy, 0);
    expect_eq("flush_late_cnt", late_cnt, 1);
    repeat (10) step();
    expect_eq("flush_nofire", dfc.size() - n0, 0);

    // Randomized traffic across a fractional rollover.
    tt = {32'd100, 64'hFFFF_FFFF_FFFF_FF00};
    for (int i = 0; i < 2000; i++) begin
      tt     = tt + 96'($urandom_range(0, 3));
      ts_v   = tt;
      cvalid = ($urandom_range(0, 3) == 0);
      r      = $urandom_range(0, 70);
      ctgt   = (r < 10) ? tt - 96'(10 - r) : tt + 96'(r - 10);
      cact   = ACT_W'($urandom);
      cflush = !fire_now && ($urandom_range(0, 199) == 0);
      step();
    end
    cflush = 1'b0;
    cvalid = 1'b0;
    repeat (60) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vita49_sched.md
Name: vita49_sched

Overview:
- Timed-command scheduler for the VITA-49 timestamp counters. Runs in one sample-clock domain, next to the timestamp generator.
- Host-side logic queues commands tagged with a target time (integer seconds plus fractional). Example actions: start/stop RX packetizer, TX burst gate, GPIO strobe.
- The block compares the head command against the live tsi/tsf and emits a one-cycle action pulse when that time is reached. This sequences the datapath against the shared timebase.

Parameters:
- DEPTH, 4, command queue depth; power of two, 2..16.
- ACT_W, 4, width of the action code.
- LCNT_W, 16, width of the saturating late-event counter.

Ports:
- samp_clk  in  1  sample clock; all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- tsi  in  32  current integer timestamp, samp_clk domain.
- tsf  in  64  current fractional timestamp, samp_clk domain.
- cmd_tsi  in  32  target integer time of the offered command.
- cmd_tsf  in  64  target fractional time of the offered command.
- cmd_action  in  ACT_W  action code of the offered command.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept a command.
- flush  in  1  synchronous clear of queue and scheduler.
- fire  out  1  one-cycle pulse: head command executed.
- fire_action  out  ACT_W  action code; valid while fire=1, else 0.
- late  out  1  one-cycle pulse with fire: target was already in the past when armed.
- late_cnt  out  LCNT_W  saturating count of late fires.
- count  out  $clog2(DEPTH)+1  commands queued, including the armed head.
- busy  out  1  state != IDLE or count != 0.

Behaviour:
- Reset (ARESETN=0, asynchronous): queue empty, state IDLE, all outputs 0 except cmd_ready=1. Reset mid-operation discards all commands; no fire is issued.
- Time compare: unsigned 96-bit {tsi,tsf} >= {tgt_tsi,tgt_tsf}. tsf does not wrap into tsi inside this block; the concatenation handles the boundary. Example: tsi=5, tsf=max is less than 6/0.
- Accept: a command is written when cmd_valid & cmd_ready at a rising edge. cmd_ready = (count != DEPTH), derived from registered count only. When full, cmd_ready=0 even if a pop occurs in the same cycle.
- count updates one edge after a push/pop. Simultaneous push and pop leaves count unchanged.
- State machine (registered):
  - IDLE: if count != 0, go to LOAD.
  - LOAD: capture head entry into tgt_tsi/tgt_tsf/tgt_act; go to ARMED.
  - ARMED: evaluate the compare every cycle with the current tsi/tsf. If true, register late = ({tsi,tsf} > target) AND (first ARMED cycle); go to FIRE.
  - FIRE: fire=1, fire_action=tgt_act, late as registered; pop the head. Go to LOAD if count > 1, else IDLE.
- Latency:
  - Accept at edge ending cycle 0 → count=1 in cycle 1 → LOAD in cycle 2 → ARMED in cycle 3.
  - An already-due command fires in cycle 4.
  - A future command fires in the cycle after the first ARMED cycle whose compare is true.
- An exact match in the first ARMED cycle fires with late=0.
- Back-to-back queued commands: fire pulses are at least 3 cycles apart (FIRE→LOAD→ARMED→FIRE). Commands fire strictly in queue order. A later entry with an earlier time fires late, immediately after its predecessor.
- late_cnt increments on each FIRE with late=1 and saturates at all-ones. It is cleared by reset only, not by flush.
- flush=1 at an edge:
  - count←0, state←IDLE; no fire that cycle even if the state was FIRE.
  - A command accepted on the same edge is discarded.
  - cmd_ready stays 1 during flush.
- fire, late and fire_action are registered outputs: glitch-free, zero while not in FIRE.

Decomposition:
- Package vita49_sched_pkg:
  - TS_W=96 constant.
  - State enum {IDLE, LOAD, ARMED, FIRE}.
  - Command struct typedef {tsi[31:0], tsf[63:0], action}; ACT_W default.
- One sub-module, vita49_sched_fifo: synchronous FIFO of DEPTH command structs.
  - Interface: push/pop/flush, count, full/empty.
  - Pointer wrap via an extra MSB.
  - Head data available combinationally from the read pointer.

Test Plan:
- Reset release, queue empty, tsi=10 → cmd_ready=1, busy=0, fire never asserts over 100 cycles.
- Future fire: tsi=10/tsf=0 incrementing tsf by 1; push {10,50,act=3} → exactly one fire with fire_action=3, late=0, one cycle after tsf=50 is presented; count 1→0.
- Late fire: tsi=20; push {19,0,act=5} at cycle 0 → fire=1, late=1 in cycle 4; late_cnt=1.
- Carry boundary: tsi=7, tsf=max; target {8,0} → no fire; next cycle tsi=8, tsf=0 → fire the cycle after, late=0.
- Full/order: push 4 commands {30,0,a1}, {30,0,a2}, {30,0,a3}, {30,0,a4} while tsi=29 → cmd_ready=0 with count=4, 5th push refused. Then tsi=30 → fires a1..a4 in order, each ≥3 cycles apart.
- Flush: 3 queued, state ARMED; flush together with a new push → count=0 next cycle, no fire, late_cnt unchanged, busy=0.
